// File: rtl/btn_duty_conditioner.sv
// Push-button front end for the PWM duty adjust: synchronise, debounce, auto-repeat
// and turn each accepted press into a fixed-width, mutually exclusive request pulse.

module btn_duty_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic repeat_en,
  output logic held,
  output logic req
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  // The timers compare against "last count before firing" so that a request lands
  // exactly REPEAT_DELAY / REPEAT_PERIOD cycles after the previous pulse rise.
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync_meta;
  logic             sync_s;
  state_t           state;
  state_t           resume_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] rel_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_s    <= sync_meta;
    end
  end

  // Request is raised on the same edge the FSM makes its firing transition.
  always_comb begin
    req = 1'b0;
    if (sync_s) begin
      case (state)
        PRESS_WAIT: req = (timer == DEB_LAST);
        HELD:       req = repeat_en && (timer == DELAY_LAST);
        REPEAT:     req = repeat_en && (timer == PERIOD_LAST);
        default:    req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      resume_state <= HELD;
      timer        <= '0;
      rel_cnt      <= '0;
      held         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_s) begin
            state <= PRESS_WAIT;
            timer <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync_s) begin
            state <= IDLE;
          end else if (timer == DEB_LAST) begin
            state <= HELD;
            timer <= '0;
            held  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        HELD: begin
          if (!sync_s) begin
            state        <= RELEASE_WAIT;
            resume_state <= HELD;
            rel_cnt      <= '0;
            if (timer != DELAY_LAST) timer <= timer + 1'b1;
          end else if (timer == DELAY_LAST) begin
            if (repeat_en) begin
              state <= REPEAT;
              timer <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        REPEAT: begin
          if (!sync_s) begin
            state        <= RELEASE_WAIT;
            resume_state <= REPEAT;
            rel_cnt      <= '0;
            if (repeat_en && (timer != PERIOD_LAST)) timer <= timer + 1'b1;
          end else if (repeat_en) begin
            if (timer == PERIOD_LAST) timer <= '0;
            else                      timer <= timer + 1'b1;
          end
        end

        // Hold/repeat timer stays frozen here so a short release only delays the schedule.
        RELEASE_WAIT: begin
          if (sync_s) begin
            state <= resume_state;
          end else if (rel_cnt == DEB_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

module btn_duty_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32,
  parameter int PULSE_WIDTH     = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  input  logic repeat_en,
  output logic increase_duty,
  output logic decrease_duty,
  output logic up_held,
  output logic dn_held
);

  localparam logic [CNT_W-1:0] PW_LOAD = CNT_W'(PULSE_WIDTH);

  logic             req_up;
  logic             req_dn;
  logic             accept_up;
  logic             accept_dn;
  logic [CNT_W-1:0] up_width;
  logic [CNT_W-1:0] dn_width;
  logic [CNT_W-1:0] up_width_next;
  logic [CNT_W-1:0] dn_width_next;

  btn_duty_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_up_raw),
    .repeat_en(repeat_en),
    .held     (up_held),
    .req      (req_up)
  );

  btn_duty_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_dn (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_dn_raw),
    .repeat_en(repeat_en),
    .held     (dn_held),
    .req      (req_dn)
  );

  // A request only wins if it is alone and neither pulse is still high; losers are lost.
  always_comb begin
    accept_up     = req_up && !req_dn && !increase_duty && !decrease_duty;
    accept_dn     = req_dn && !req_up && !increase_duty && !decrease_duty;
    up_width_next = '0;
    dn_width_next = '0;
    if (accept_up)          up_width_next = PW_LOAD;
    else if (up_width != 0) up_width_next = up_width - 1'b1;
    if (accept_dn)          dn_width_next = PW_LOAD;
    else if (dn_width != 0) dn_width_next = dn_width - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_width      <= '0;
      dn_width      <= '0;
      increase_duty <= 1'b0;
      decrease_duty <= 1'b0;
    end else begin
      up_width      <= up_width_next;
      dn_width      <= dn_width_next;
      increase_duty <= (up_width_next != 0);
      decrease_duty <= (dn_width_next != 0);
    end
  end

endmodule

// File: tb/tb_btn_duty_conditioner.sv
// Bench for btn_duty_conditioner: segment table, directed corner sequences and
// random button activity compared against a run-length reference model.

module tb_btn_duty_conditioner;

  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RP = 32;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up_raw = 1'b0;
  logic btn_dn_raw = 1'b0;
  logic repeat_en = 1'b0;
  logic increase_duty, decrease_duty, up_held, dn_held;

  int checks = 0;
  int errors = 0;
  int edge_idx = -1;
  bit model_on = 1'b0;

  typedef struct {
    bit do_reset;
    bit up;
    bit dn;
    bit rep;
    int len;
    bit inc;
    bit dec;
    bit uph;
    bit dnh;
  } seg_t;

  seg_t segs[$];

  // Reference model state: raw history, run length of samples opposing the held level,
  // cycles counted toward the next request, and the edge of each channel's last pulse rise.
  bit m_h1[2];
  bit m_h2[2];
  bit m_held[2];
  int m_run[2];
  bit m_rep_phase[2];
  int m_elapsed[2];
  int m_rise[2];
  int m_edge;

  btn_duty_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .PULSE_WIDTH    (PW),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up_raw   (btn_up_raw),
    .btn_dn_raw   (btn_dn_raw),
    .repeat_en    (repeat_en),
    .increase_duty(increase_duty),
    .decrease_duty(decrease_duty),
    .up_held      (up_held),
    .dn_held      (dn_held)
  );

  always #5 clk = ~clk;

  function automatic bit pulse_on(input int c, input int e);
    return (e - m_rise[c] >= 0) && (e - m_rise[c] < PW);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_h1[c] = 1'b0;
      m_h2[c] = 1'b0;
      m_held[c] = 1'b0;
      m_run[c] = 0;
      m_rep_phase[c] = 1'b0;
      m_elapsed[c] = 0;
      m_rise[c] = -1000;
    end
    m_edge = 0;
  endtask

  task automatic model_step(input bit raw_up, input bit raw_dn, input bit rep);
    bit req[2];
    bit raw[2];
    bit s;
    bit in_rw;
    bit may_adv;
    int target;
    bit busy;
    raw[0] = raw_up;
    raw[1] = raw_dn;
    busy = pulse_on(0, m_edge - 1) || pulse_on(1, m_edge - 1);
    for (int c = 0; c < 2; c++) begin
      req[c] = 1'b0;
      s = m_h2[c];
      m_h2[c] = m_h1[c];
      m_h1[c] = raw[c];
      if (!m_held[c]) begin
        m_run[c] = s ? m_run[c] + 1 : 0;
        if (m_run[c] == D + 2) begin
          m_held[c] = 1'b1;
          m_run[c] = 0;
          req[c] = 1'b1;
          m_rep_phase[c] = 1'b0;
          m_elapsed[c] = 0;
        end
      end else begin
        in_rw = (m_run[c] > 0);
        target = m_rep_phase[c] ? RP : RD;
        may_adv = !m_rep_phase[c] || rep;
        if (!s) begin
          if (!in_rw && may_adv && (m_elapsed[c] + 1 < target)) m_elapsed[c]++;
          m_run[c]++;
          if (m_run[c] == D + 2) begin
            m_held[c] = 1'b0;
            m_run[c] = 0;
          end
        end else begin
          if (!in_rw) begin
            if (rep && (m_elapsed[c] + 1 >= target)) begin
              req[c] = 1'b1;
              m_elapsed[c] = 0;
              m_rep_phase[c] = 1'b1;
            end else if (may_adv && (m_elapsed[c] + 1 < target)) begin
              m_elapsed[c]++;
            end
          end
          m_run[c] = 0;
        end
      end
    end
    if ((req[0] != req[1]) && !busy) begin
      for (int c = 0; c < 2; c++) if (req[c]) m_rise[c] = m_edge;
    end
    m_edge++;
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input bit rep);
    btn_up_raw = up;
    btn_dn_raw = dn;
    repeat_en  = rep;
    @(posedge clk);
    edge_idx++;
    if (model_on) model_step(up, dn, rep);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit e_inc, input bit e_dec,
                             input bit e_uph, input bit e_dnh);
    logic [3:0] got;
    logic [3:0] exp;
    got = {increase_duty, decrease_duty, up_held, dn_held};
    exp = {e_inc, e_dec, e_uph, e_dnh};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: inc,dec,up_held,dn_held got %b required %b",
               name, edge_idx, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_up_raw = 1'b0;
    btn_dn_raw = 1'b0;
    repeat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    edge_idx = -1;
  endtask

  task automatic add_seg(input bit r, input bit up, input bit dn, input bit rep, input int len,
                         input bit inc, input bit dec, input bit uph, input bit dnh);
    seg_t sg;
    sg.do_reset = r;  sg.up = up;   sg.dn = dn;   sg.rep = rep; sg.len = len;
    sg.inc = inc;     sg.dec = dec; sg.uph = uph; sg.dnh = dnh;
    segs.push_back(sg);
  endtask

  initial begin
    bit lvl[2];
    int seg_left[2];
    bit rep;
    bit e_dec;

    $display("[TB] btn_duty_conditioner bench start");

    // Single press, no repeat
    add_seg(1, 1, 0, 0, 19, 0, 0, 0, 0);
    add_seg(0, 1, 0, 0,  4, 1, 0, 1, 0);
    add_seg(0, 1, 0, 0, 17, 0, 0, 1, 0);
    add_seg(0, 0, 0, 0, 19, 0, 0, 1, 0);
    add_seg(0, 0, 0, 0,  5, 0, 0, 0, 0);
    // Auto-repeat on down: rises at 19, 83, 115, 147, 179, release at 200
    add_seg(1, 0, 1, 1, 19, 0, 0, 0, 0);
    add_seg(0, 0, 1, 1,  4, 0, 1, 0, 1);
    add_seg(0, 0, 1, 1, 60, 0, 0, 0, 1);
    add_seg(0, 0, 1, 1,  4, 0, 1, 0, 1);
    add_seg(0, 0, 1, 1, 28, 0, 0, 0, 1);
    add_seg(0, 0, 1, 1,  4, 0, 1, 0, 1);
    add_seg(0, 0, 1, 1, 28, 0, 0, 0, 1);
    add_seg(0, 0, 1, 1,  4, 0, 1, 0, 1);
    add_seg(0, 0, 1, 1, 28, 0, 0, 0, 1);
    add_seg(0, 0, 1, 1,  4, 0, 1, 0, 1);
    add_seg(0, 0, 1, 1, 17, 0, 0, 0, 1);
    add_seg(0, 0, 0, 1, 19, 0, 0, 0, 1);
    add_seg(0, 0, 0, 1, 20, 0, 0, 0, 0);
    // Simultaneous press: both requests dropped, both held
    add_seg(1, 1, 1, 0, 19, 0, 0, 0, 0);
    add_seg(0, 1, 1, 0, 21, 0, 0, 1, 1);
    add_seg(0, 0, 0, 0, 19, 0, 0, 1, 1);
    add_seg(0, 0, 0, 0,  3, 0, 0, 0, 0);
    // Saturated hold timer, then repeat enabled at edge 150: fires at once, then +32
    add_seg(1, 1, 0, 0,  19, 0, 0, 0, 0);
    add_seg(0, 1, 0, 0,   4, 1, 0, 1, 0);
    add_seg(0, 1, 0, 0, 127, 0, 0, 1, 0);
    add_seg(0, 1, 0, 1,   4, 1, 0, 1, 0);
    add_seg(0, 1, 0, 1,  28, 0, 0, 1, 0);
    add_seg(0, 1, 0, 1,   4, 1, 0, 1, 0);
    add_seg(0, 0, 0, 0,  19, 0, 0, 1, 0);
    add_seg(0, 0, 0, 0,   3, 0, 0, 0, 0);

    foreach (segs[i]) begin
      if (segs[i].do_reset) do_reset();
      for (int k = 0; k < segs[i].len; k++) begin
        applyStimulus(segs[i].up, segs[i].dn, segs[i].rep);
        checkOutput($sformatf("seg%0d", i), segs[i].inc, segs[i].dec, segs[i].uph, segs[i].dnh);
      end
    end

    // Bounce: 10-cycle bursts with 3-cycle gaps never qualify
    do_reset();
    for (int k = 0; k < 100; k++) begin
      applyStimulus((k % 13) < 10, 1'b0, 1'b0);
      checkOutput("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Release glitch of 5 cycles while held delays the repeat schedule by 5
    do_reset();
    for (int e = 0; e < 130; e++) begin
      applyStimulus(1'b0, !(e >= 40 && e < 45), 1'b1);
      e_dec = (e >= 19 && e <= 22) || (e >= 88 && e <= 91) || (e >= 120 && e <= 123);
      checkOutput("glitch", 1'b0, e_dec, 1'b0, e >= 19);
    end

    // Asynchronous reset during a pulse, then a fresh press with the button still down
    do_reset();
    for (int e = 0; e <= 20; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pre_rst", e >= 19, 1'b0, e >= 19, 1'b0);
    end
    rst = 1'b0;
    #1;
    checkOutput("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    edge_idx = -1;
    for (int e = 0; e < 25; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("post_rst", e >= 19 && e <= 22, 1'b0, e >= 19, 1'b0);
    end

    // Random button activity against the reference model
    do_reset();
    model_reset();
    model_on = 1'b1;
    lvl[0] = 1'b0;
    lvl[1] = 1'b0;
    seg_left[0] = 5;
    seg_left[1] = 30;
    rep = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (seg_left[c] == 0) begin
          lvl[c] = !lvl[c];
          seg_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20))
                                                    : int'($urandom_range(20, 250));
        end
        seg_left[c]--;
      end
      if ($urandom_range(0, 149) == 0) rep = !rep;
      applyStimulus(lvl[0], lvl[1], rep);
      checkOutput("random", pulse_on(0, m_edge - 1), pulse_on(1, m_edge - 1),
                  m_held[0], m_held[1]);
    end
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
